// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache refills.
// Optional perf counters enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req_valid,
   output logic              ic_req_ready,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_resp_valid,
   output logic [DATA_W-1:0] ic_resp_data,
   input  logic              dc_req_valid,
   output logic              dc_req_ready,
   input  logic              dc_req_rnw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic              dc_wdata_valid,
   output logic              dc_wdata_ready,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_resp_valid,
   output logic [DATA_W-1:0] dc_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rnw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_wdata_valid,
   input  logic              mem_wdata_ready,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              busy,
   output logic              grant_dc
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_ic_grants,
   output logic [31:0]       perf_dc_grants,
   output logic [31:0]       perf_stall_cycles
`endif
);

   localparam int CW = $clog2(BEATS) + 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rnw_q, rnw_d;
   logic              last_q, last_d;
   logic              grant_q, grant_d;
   logic              win_dc;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      addr_d          = addr_q;
      rnw_d           = rnw_q;
      last_d          = last_q;
      grant_d         = grant_q;
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      ic_resp_valid   = 1'b0;
      ic_resp_data    = '0;
      dc_resp_valid   = 1'b0;
      dc_resp_data    = '0;
      dc_wdata_ready  = 1'b0;
      mem_req_valid   = 1'b0;
      mem_req_rnw     = 1'b0;
      mem_req_addr    = '0;
      mem_wdata_valid = 1'b0;
      mem_wdata       = '0;
      // On a tie the requester that did not win last time goes first
      win_dc = dc_req_valid & (~ic_req_valid | ~last_q);
      unique case (state_q)
         IDLE: begin
            ic_req_ready = ic_req_valid & ~win_dc;
            dc_req_ready = win_dc;
            if (win_dc) begin
               addr_d  = dc_req_addr;
               rnw_d   = dc_req_rnw;
               grant_d = 1'b1;
               last_d  = 1'b1;
               state_d = ADDR;
            end else if (ic_req_valid) begin
               addr_d  = ic_req_addr;
               rnw_d   = 1'b1;
               grant_d = 1'b0;
               last_d  = 1'b0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            mem_req_valid = 1'b1;
            mem_req_rnw   = rnw_q;
            mem_req_addr  = addr_q;
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = rnw_q ? RDATA : WDATA;
            end
         end
         WDATA: begin
            mem_wdata_valid = dc_wdata_valid;
            mem_wdata       = dc_wdata;
            dc_wdata_ready  = mem_wdata_ready;
            if (dc_wdata_valid && mem_wdata_ready) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) state_d = IDLE;
            end
         end
         RDATA: begin
            ic_resp_valid = ~grant_q & mem_resp_valid;
            dc_resp_valid = grant_q & mem_resp_valid;
            ic_resp_data  = grant_q ? '0 : mem_resp_data;
            dc_resp_data  = grant_q ? mem_resp_data : '0;
            if (mem_resp_valid) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rnw_q   <= 1'b1;
         last_q  <= 1'b0;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rnw_q   <= rnw_d;
         last_q  <= last_d;
         grant_q <= grant_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign grant_dc = grant_q;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] pic_q, pic_d;
   logic [31:0] pdc_q, pdc_d;
   logic [31:0] pst_q, pst_d;
   logic        stall;

   always_comb begin
      stall = (ic_req_valid & ~ic_req_ready) | (dc_req_valid & ~dc_req_ready);
      pic_d = pic_q + 32'(ic_req_valid & ic_req_ready);
      pdc_d = pdc_q + 32'(dc_req_valid & dc_req_ready);
      pst_d = pst_q + 32'(stall);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pic_q <= '0;
         pdc_q <= '0;
         pst_q <= '0;
      end else begin
         pic_q <= pic_d;
         pdc_q <= pdc_d;
         pst_q <= pst_d;
      end
   end

   assign perf_ic_grants    = pic_q;
   assign perf_dc_grants    = pdc_q;
   assign perf_stall_cycles = pst_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BEATS = 4;

   logic clk = 1'b0;
   logic reset;
   logic ic_req_valid, ic_req_ready, ic_resp_valid;
   logic [AW-1:0] ic_req_addr;
   logic [DW-1:0] ic_resp_data;
   logic dc_req_valid, dc_req_ready, dc_req_rnw;
   logic [AW-1:0] dc_req_addr;
   logic dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
   logic [DW-1:0] dc_wdata, dc_resp_data;
   logic mem_req_valid, mem_req_ready, mem_req_rnw;
   logic [AW-1:0] mem_req_addr;
   logic mem_wdata_valid, mem_wdata_ready;
   logic [DW-1:0] mem_wdata;
   logic mem_resp_valid;
   logic [DW-1:0] mem_resp_data;
   logic busy, grant_dc;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_ic_grants, perf_dc_grants, perf_stall_cycles;
`endif

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(BEATS)) dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
      .ic_req_addr(ic_req_addr), .ic_resp_valid(ic_resp_valid),
      .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
      .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
      .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
      .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid),
      .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
      .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
      .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data),
      .busy(busy), .grant_dc(grant_dc)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   int n_tests = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit pct(input int p);
      return $urandom_range(99) < p;
   endfunction

   // stimulus knobs
   int req_pct = 100, rsp_pct = 100, wr_pct = 100;
   bit stray = 0, wr_toggle = 0, wd_script = 0, wd_rand = 0;
   int wr_base = 0;

   // observation logs
   logic [31:0] rd_q[$], script_q[$];
   logic [31:0] ic_got[$], dc_got[$], wr_log[$], addr_log[$];
   bit grant_log[$], rnw_log[$];
   int ic_hs_n = 0, dc_hs_n = 0;

   // transaction-level reference: one outstanding line transfer at a time
   bit m_act = 0, m_aph = 0, m_rnw = 1, m_last = 0, m_grant = 0;
   logic [31:0] m_addr = 0;
   int m_done = 0;
   int unsigned m_pic = 0, m_pdc = 0, m_pst = 0;

   always @(negedge clk) begin
      bit idle, wdc, e_icr, e_dcr, wph, rph;
      if (reset) begin
         m_act = 0; m_aph = 0; m_last = 0; m_grant = 0; m_done = 0;
         m_pic = 0; m_pdc = 0; m_pst = 0;
         chk("rst_data", ic_resp_data | dc_resp_data | mem_wdata | mem_req_addr, 0);
      end
      idle = !m_act;
      wdc = dc_req_valid && (!ic_req_valid || !m_last);
      e_icr = idle && ic_req_valid && !wdc;
      e_dcr = idle && wdc;
      wph = m_act && !m_aph && !m_rnw;
      rph = m_act && !m_aph && m_rnw;
      chk("ic_req_ready", ic_req_ready, e_icr);
      chk("dc_req_ready", dc_req_ready, e_dcr);
      chk("busy", busy, m_act);
      chk("grant_dc", grant_dc, m_grant);
      chk("mem_req_valid", mem_req_valid, m_act && m_aph);
      if (m_act && m_aph) begin
         chk("mem_req_addr", mem_req_addr, m_addr);
         chk("mem_req_rnw", mem_req_rnw, m_rnw);
      end
      chk("mem_wdata_valid", mem_wdata_valid, wph && dc_wdata_valid);
      chk("dc_wdata_ready", dc_wdata_ready, wph && mem_wdata_ready);
      if (wph && dc_wdata_valid) chk("mem_wdata", mem_wdata, dc_wdata);
      chk("ic_resp_valid", ic_resp_valid, rph && !m_grant && mem_resp_valid);
      chk("dc_resp_valid", dc_resp_valid, rph && m_grant && mem_resp_valid);
      if (rph && mem_resp_valid)
         chk("resp_data", m_grant ? dc_resp_data : ic_resp_data, mem_resp_data);
`ifdef MEM_ARB_PERF_EN
      chk("perf_ic", perf_ic_grants, m_pic);
      chk("perf_dc", perf_dc_grants, m_pdc);
      chk("perf_stall", perf_stall_cycles, m_pst);
`endif
      if (!reset) begin
         if (ic_req_valid && ic_req_ready) begin ic_hs_n++; grant_log.push_back(0); end
         if (dc_req_valid && dc_req_ready) begin dc_hs_n++; grant_log.push_back(1); end
         if (ic_resp_valid) ic_got.push_back(ic_resp_data);
         if (dc_resp_valid) dc_got.push_back(dc_resp_data);
         if (mem_wdata_valid && mem_wdata_ready) wr_log.push_back(mem_wdata);
         if (mem_req_valid && mem_req_ready) begin
            addr_log.push_back(mem_req_addr);
            rnw_log.push_back(mem_req_rnw);
            if (mem_req_rnw)
               repeat (BEATS)
                  rd_q.push_back(script_q.size() > 0 ? script_q.pop_front() : $urandom);
         end
         if ((ic_req_valid && !e_icr) || (dc_req_valid && !e_dcr)) m_pst++;
         if (idle) begin
            if (e_icr || e_dcr) begin
               m_act = 1; m_aph = 1; m_done = 0;
               m_rnw = wdc ? dc_req_rnw : 1'b1;
               m_addr = wdc ? dc_req_addr : ic_req_addr;
               m_last = wdc; m_grant = wdc;
               if (wdc) m_pdc++; else m_pic++;
            end
         end else if (m_aph) begin
            if (mem_req_ready) m_aph = 0;
         end else if ((wph && dc_wdata_valid && mem_wdata_ready) ||
                      (rph && mem_resp_valid)) begin
            m_done++;
            if (m_done == BEATS) m_act = 0;
         end
      end
   end

   // memory side and dcache write-data source
   always begin
      @(posedge clk);
      #1;
      mem_req_ready = pct(req_pct);
      mem_wdata_ready = wr_toggle ? !mem_wdata_ready : pct(wr_pct);
      if (rd_q.size() > 0 && pct(rsp_pct)) begin
         mem_resp_valid = 1;
         mem_resp_data = rd_q.pop_front();
      end else if (stray && pct(10)) begin
         mem_resp_valid = 1;
         mem_resp_data = $urandom;
      end else begin
         mem_resp_valid = 0;
         mem_resp_data = 0;
      end
      if (wd_script) begin
         dc_wdata_valid = 1;
         dc_wdata = 32'hA0 + 32'(wr_log.size() - wr_base);
      end else if (wd_rand) begin
         dc_wdata_valid = pct(70);
         dc_wdata = $urandom;
      end else begin
         dc_wdata_valid = 0;
         dc_wdata = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin step(); n++; end
      chk("idle_timeout", busy, 0);
      step();
   endtask

   task automatic wait_ic_hs(input int h0);
      int n = 0;
      while (ic_hs_n == h0 && n < 40) begin step(); n++; end
      chk("ic_hs", ic_hs_n, h0 + 1);
   endtask

   task automatic wait_dc_hs(input int h0);
      int n = 0;
      while (dc_hs_n == h0 && n < 40) begin step(); n++; end
      chk("dc_hs", dc_hs_n, h0 + 1);
   endtask

   logic [31:0] t1_lit[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
   bit t3_lit[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int i0, d0, a0, g0, w0, n, hi, hd;
      ic_req_valid = 0; ic_req_addr = 0;
      dc_req_valid = 0; dc_req_rnw = 1; dc_req_addr = 0;
      dc_wdata_valid = 0; dc_wdata = 0;
      mem_req_ready = 0; mem_wdata_ready = 0;
      mem_resp_valid = 0; mem_resp_data = 0;
      reset = 1;
      repeat (2) step();
      reset = 0;
      step();

      // single icache read
      i0 = ic_got.size(); d0 = dc_got.size(); a0 = addr_log.size();
      script_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      ic_req_valid = 1; ic_req_addr = 32'h1000;
      wait_ic_hs(ic_hs_n);
      ic_req_valid = 0;
      wait_idle();
      chk("t1_nbeats", ic_got.size() - i0, 4);
      if (ic_got.size() >= i0 + 4)
         for (int k = 0; k < 4; k++) chk("t1_beat", ic_got[i0 + k], t1_lit[k]);
      if (addr_log.size() > a0) begin
         chk("t1_addr", addr_log[a0], 32'h1000);
         chk("t1_rnw", rnw_log[a0], 1);
      end
      chk("t1_dc_quiet", dc_got.size() - d0, 0);

      // dcache write with toggling write-ready
      i0 = ic_got.size(); d0 = dc_got.size(); w0 = wr_log.size();
      wr_base = w0; wd_script = 1; wr_toggle = 1;
      dc_req_valid = 1; dc_req_rnw = 0; dc_req_addr = 32'h2000;
      wait_dc_hs(dc_hs_n);
      dc_req_valid = 0;
      wait_idle();
      wd_script = 0; wr_toggle = 0;
      chk("t2_nbeats", wr_log.size() - w0, 4);
      if (wr_log.size() >= w0 + 4)
         for (int k = 0; k < 4; k++) chk("t2_beat", wr_log[w0 + k], 32'hA0 + k);
      chk("t2_no_resp", (ic_got.size() - i0) + (dc_got.size() - d0), 0);

      // simultaneous requests after reset
      reset = 1; step(); reset = 0; step();
      g0 = grant_log.size();
      repeat (2) begin
         ic_req_valid = 1; ic_req_addr = $urandom;
         dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = $urandom;
         hi = ic_hs_n; hd = dc_hs_n; n = 0;
         while ((ic_req_valid || dc_req_valid) && n < 80) begin
            step(); n++;
            if (ic_hs_n != hi) ic_req_valid = 0;
            if (dc_hs_n != hd) dc_req_valid = 0;
         end
         ic_req_valid = 0; dc_req_valid = 0;
         wait_idle();
      end
      chk("t3_ngrants", grant_log.size() - g0, 4);
      if (grant_log.size() >= g0 + 4)
         for (int k = 0; k < 4; k++) chk("t3_order", grant_log[g0 + k], t3_lit[k]);

      // address phase held off by memory
      req_pct = 0;
      ic_req_valid = 1; ic_req_addr = 32'h3000;
      hd = dc_hs_n;
      wait_ic_hs(ic_hs_n);
      ic_req_valid = 0;
      dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = 32'h4000;
      repeat (5) begin
         step();
         chk("t4_valid", mem_req_valid, 1);
         chk("t4_addr", mem_req_addr, 32'h3000);
         chk("t4_rnw", mem_req_rnw, 1);
         chk("t4_no_ready", {ic_req_ready, dc_req_ready}, 0);
      end
      req_pct = 100;
      wait_dc_hs(hd);
      dc_req_valid = 0;
      wait_idle();

      // reset in the middle of a dcache read
      d0 = dc_got.size();
      script_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = 32'h5000;
      wait_dc_hs(dc_hs_n);
      dc_req_valid = 0;
      n = 0;
      while (dc_got.size() < d0 + 2 && n < 30) begin step(); n++; end
      #2;
      reset = 1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_resp_valid", dc_resp_valid, 0);
      chk("t5_resp_data", dc_resp_data, 0);
      chk("t5_req_valid", mem_req_valid, 0);
      chk("t5_grant", grant_dc, 0);
      @(negedge clk);
      #2;
      reset = 0;
      step();
      n = 0;
      while (rd_q.size() > 0 && n < 20) begin step(); n++; end
      step();
      chk("t5_dropped", dc_got.size() - d0, 2);
      if (dc_got.size() >= d0 + 2) begin
         chk("t5_beat0", dc_got[d0], 32'hB0);
         chk("t5_beat1", dc_got[d0 + 1], 32'hB1);
      end
      i0 = ic_got.size();
      ic_req_valid = 1; ic_req_addr = 32'h6000;
      wait_ic_hs(ic_hs_n);
      ic_req_valid = 0;
      wait_idle();
      chk("t5_next_read", ic_got.size() - i0, 4);

      // randomized traffic
      req_pct = 70; rsp_pct = 70; wr_pct = 60; stray = 1; wd_rand = 1;
      hi = ic_hs_n; hd = dc_hs_n;
      repeat (4000) begin
         step();
         if (ic_hs_n != hi) begin
            hi = ic_hs_n;
            ic_req_valid = pct(30);
            ic_req_addr = $urandom;
         end else if (!ic_req_valid) begin
            if (pct(25)) begin ic_req_valid = 1; ic_req_addr = $urandom; end
         end else if (pct(3)) ic_req_valid = 0;
         if (dc_hs_n != hd) begin
            hd = dc_hs_n;
            dc_req_valid = pct(30);
            dc_req_rnw = pct(50);
            dc_req_addr = $urandom;
         end else if (!dc_req_valid) begin
            if (pct(25)) begin
               dc_req_valid = 1; dc_req_rnw = pct(50); dc_req_addr = $urandom;
            end
         end else if (pct(3)) dc_req_valid = 0;
         if (reset) reset = 0;
         else if ($urandom_range(399) == 0) reset = 1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
